// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller for the single-cycle 32x32 Booth multiplier datapath.
// Optional last-result reuse (skips the datapath on a repeat operand pair): define MUL_RESULT_REUSE_EN.
module mul_issue_ctrl #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic [31:0]      i_req_a,
    input  logic [31:0]      i_req_b,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic [31:0]      o_mul_a,
    output logic [31:0]      o_mul_b,
    output logic             o_mul_signed,
    input  logic [63:0]      i_mul_prod,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_done_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t           r_state;
    logic [31:0]      r_mulA;
    logic [31:0]      r_mulB;
    logic             r_mulSigned;
    logic [1:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_rspValid;
    logic [31:0]      r_rspData;
    logic [TAG_W-1:0] r_rspTag;
    logic [CNT_W-1:0] r_doneCnt;

    logic        w_reqReady;
    logic        w_reqFire;
    logic        w_rspFire;
    logic [31:0] w_corrHi;
    logic [31:0] w_result;
    logic        w_hit;
    logic [31:0] w_hitData;

    assign w_reqReady = (r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready);
    assign w_reqFire  = i_req_valid && w_reqReady;
    assign w_rspFire  = r_rspValid && i_rsp_ready;

    // MULHSU runs unsigned; subtracting b from the high word restores rs1's sign weight.
    assign w_corrHi = i_mul_prod[63:32] -
                      (((r_op == OP_MULHSU) && r_mulA[31]) ? r_mulB : 32'd0);
    assign w_result = (r_op == OP_MUL) ? i_mul_prod[31:0] : w_corrHi;

`ifdef MUL_RESULT_REUSE_EN
    logic        r_cValid;
    logic [31:0] r_cA;
    logic [31:0] r_cB;
    logic [1:0]  r_cMode;
    logic [31:0] r_cLo;
    logic [31:0] r_cHi;

    function automatic logic [1:0] modeOf(input logic [1:0] op);
        case (op)
            OP_MULH:   modeOf = 2'd1;
            OP_MULHSU: modeOf = 2'd2;
            default:   modeOf = 2'd0;
        endcase
    endfunction

    // The low product word is identical for every signedness, so MUL hits any cached mode.
    assign w_hit = r_cValid && (i_req_a == r_cA) && (i_req_b == r_cB) &&
                   ((modeOf(i_req_op) == r_cMode) || (i_req_op == OP_MUL));
    assign w_hitData = (i_req_op == OP_MUL) ? r_cLo : r_cHi;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cValid <= 1'b0;
            r_cA     <= '0;
            r_cB     <= '0;
            r_cMode  <= '0;
            r_cLo    <= '0;
            r_cHi    <= '0;
        end else if (r_state == S_CALC) begin
            r_cValid <= 1'b1;
            r_cA     <= r_mulA;
            r_cB     <= r_mulB;
            r_cMode  <= modeOf(r_op);
            r_cLo    <= i_mul_prod[31:0];
            r_cHi    <= w_corrHi;
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hitData = 32'd0;
`endif

    // Later assignments take priority: a new request in RESP overrides the return to IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_mulA      <= '0;
            r_mulB      <= '0;
            r_mulSigned <= 1'b0;
            r_op        <= OP_MUL;
            r_tag       <= '0;
            r_rspValid  <= 1'b0;
            r_rspData   <= '0;
            r_rspTag    <= '0;
            r_doneCnt   <= '0;
        end else begin
            if (w_rspFire) begin
                r_rspValid <= 1'b0;
                r_state    <= S_IDLE;
                if (r_doneCnt != {CNT_W{1'b1}}) begin
                    r_doneCnt <= r_doneCnt + 1'b1;
                end
            end
            if (w_reqFire) begin
                if (w_hit) begin
                    r_rspValid <= 1'b1;
                    r_rspData  <= w_hitData;
                    r_rspTag   <= i_req_tag;
                    r_state    <= S_RESP;
                end else begin
                    r_mulA      <= i_req_a;
                    r_mulB      <= i_req_b;
                    r_mulSigned <= (i_req_op == OP_MULH);
                    r_op        <= i_req_op;
                    r_tag       <= i_req_tag;
                    r_state     <= S_CALC;
                end
            end
            if (r_state == S_CALC) begin
                r_rspValid <= 1'b1;
                r_rspData  <= w_result;
                r_rspTag   <= r_tag;
                r_state    <= S_RESP;
            end
        end
    end

    assign o_req_ready  = w_reqReady;
    assign o_mul_a      = r_mulA;
    assign o_mul_b      = r_mulB;
    assign o_mul_signed = r_mulSigned;
    assign o_rsp_valid  = r_rspValid;
    assign o_rsp_data   = r_rspData;
    assign o_rsp_tag    = r_rspTag;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done_cnt   = r_doneCnt;

endmodule
